// File: rtl/test_pattern_gen_if.sv
// Pixel stream bundle: pixel + valid/ready + frame markers.
// master drives pixel/valid/sof/eol/eof, slave drives ready_in.
interface test_pattern_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] pixel_out;
  logic              valid_out;
  logic              sof_out;
  logic              eol_out;
  logic              eof_out;
  logic              ready_in;

  modport master (
    output pixel_out, valid_out,
    output sof_out, eol_out, eof_out,
    input  ready_in
  );

  modport slave (
    input  pixel_out, valid_out,
    input  sof_out, eol_out, eof_out,
    output ready_in
  );
endinterface

// File: rtl/test_pattern_gen.sv
// Synthetic WIDTH x HEIGHT video source with selectable patterns.
// Ports: clk, rst_n, enable, mode, frame_cnt, vid (stream master).
module test_pattern_gen #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int DATA_W     = 8,
  parameter int CHECK_LOG2 = 1,
  parameter int HBLANK     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] mode,
  output logic [7:0] frame_cnt,
  test_pattern_gen_if.master vid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam int NB0 = WIDTH >> CHECK_LOG2;
  localparam int NBAR = (NB0 > 0) ? NB0 : 1;
  localparam logic [DATA_W-1:0] MAX = '1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_BLANK
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [2:0]        mode_q, mode_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic [7:0]        fcnt_d;
  logic              load, drop, xfer;

  logic [DATA_W-1:0] pix_q;
  logic              valid_q, sof_q, eol_q, eof_q;

  assign vid.pixel_out = pix_q;
  assign vid.valid_out = valid_q;
  assign vid.sof_out   = sof_q;
  assign vid.eol_out   = eol_q;
  assign vid.eof_out   = eof_q;

  function automatic logic [DATA_W-1:0] pattern(
    logic [2:0] m, int r, int c, int f
  );
    logic [DATA_W-1:0] p;
    p = '0;
    case (m)
      3'd0: p = ((((r ^ c) >> CHECK_LOG2) & 1) != 0)
                ? MAX : '0;
      3'd1: p = DATA_W'(c);
      3'd2: p = DATA_W'(r);
      3'd3: p = MAX;
      3'd4: p = DATA_W'(r + c);
      3'd5: p = ((c >> CHECK_LOG2) == (f % NBAR))
                ? MAX : '0;
      default: p = '0;
    endcase
    return p;
  endfunction

  assign xfer = valid_q && vid.ready_in;

  // load: present the beat at row_d/col_d next cycle.
  // drop: retire the stream (idle or blanking).
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    fcnt_d  = frame_cnt;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ACTIVE;
          mode_d  = mode;
          row_d   = '0;
          col_d   = '0;
          load    = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          if (!eol_q) begin
            col_d = col_q + CW'(1);
            load  = 1'b1;
          end else begin
            col_d = '0;
            if (eof_q) begin
              row_d  = '0;
              fcnt_d = frame_cnt + 8'd1;
            end else begin
              row_d = row_q + RW'(1);
            end
            if (eof_q && !enable) begin
              state_d = S_IDLE;
              drop    = 1'b1;
            end else begin
              if (eof_q) mode_d = mode;
              if (HBLANK > 0) begin
                state_d = S_BLANK;
                blank_d = BW'(HBLANK - 1);
                drop    = 1'b1;
              end else begin
                load = 1'b1;
              end
            end
          end
        end
      end
      S_BLANK: begin
        if (blank_q == '0) begin
          state_d = S_ACTIVE;
          load    = 1'b1;
        end else begin
          blank_d = blank_q - BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      mode_q    <= '0;
      blank_q   <= '0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      mode_q    <= mode_d;
      blank_q   <= blank_d;
      frame_cnt <= fcnt_d;
    end
  end

  // Outputs hold while stalled; they only move on load/drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (load) begin
      pix_q   <= pattern(mode_d, int'(row_d),
                         int'(col_d), int'(fcnt_d));
      valid_q <= 1'b1;
      sof_q   <= (row_d == '0) && (col_d == '0);
      eol_q   <= (col_d == COL_LAST);
      eof_q   <= (col_d == COL_LAST) && (row_d == ROW_LAST);
    end else if (drop) begin
      pix_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: scoreboard + vector table.
// Two instances: HBLANK=0 (main) and HBLANK=3 (blanking).
module tb_test_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, en_b;
  logic [2:0] mode, mode_b;
  logic [7:0] fcnt_a, fcnt_b;
  logic       bp_en = 1'b0;

  always #5 clk = ~clk;

  test_pattern_gen_if #(.DATA_W(8)) vif_a ();
  test_pattern_gen_if #(.DATA_W(8)) vif_b ();

  test_pattern_gen #(
    .WIDTH(8), .HEIGHT(8), .DATA_W(8),
    .CHECK_LOG2(1), .HBLANK(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .enable(enable), .mode(mode),
    .frame_cnt(fcnt_a), .vid(vif_a.master)
  );

  test_pattern_gen #(
    .WIDTH(8), .HEIGHT(8), .DATA_W(8),
    .CHECK_LOG2(1), .HBLANK(3)
  ) u_hb (
    .clk(clk), .rst_n(rst_n),
    .enable(en_b), .mode(mode_b),
    .frame_cnt(fcnt_b), .vid(vif_b.master)
  );

  typedef struct {
    logic [2:0] m;
    int         r;
    int         c;
    logic [7:0] pix;
    logic       sof, eol, eof;
  } exp_t;

  typedef struct {
    logic [2:0] m;
    int         r;
    int         c;
    logic [7:0] exp;
  } vec_t;

  exp_t       q[$];
  exp_t       e_mon;
  vec_t       vt[14];
  logic [7:0] cap[8][8][8];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_beats = 0;
  int         fc = 0;
  int         base;
  logic       stall_prev = 1'b0;
  logic [11:0] held;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act,
                      input int exp);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  function automatic logic [7:0] model(logic [2:0] m, int r,
                                       int c, int f);
    case (m)
      3'd0: return (((r / 2) % 2) != ((c / 2) % 2)) ? 8'hFF : 8'h00;
      3'd1: return 8'(c);
      3'd2: return 8'(r);
      3'd3: return 8'hFF;
      3'd4: return 8'((r + c) % 256);
      3'd5: return ((c / 2) == (f % 4)) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_frame(input logic [2:0] m, input int f);
    exp_t e;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        e.m   = m;
        e.r   = r;
        e.c   = c;
        e.pix = model(m, r, c, f);
        e.sof = (r == 0) && (c == 0);
        e.eol = (c == 7);
        e.eof = (c == 7) && (r == 7);
        q.push_back(e);
      end
  endtask

  task automatic wait_beats(input int tgt, input int budget);
    int n = 0;
    while (n_beats < tgt && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n_beats < tgt) fail("beat_timeout", n_beats, tgt);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    vif_a.ready_in = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold",
              {vif_a.valid_out, vif_a.sof_out, vif_a.eol_out,
               vif_a.eof_out, vif_a.pixel_out}, held);
      if (vif_a.valid_out && vif_a.ready_in) begin
        if (q.size() == 0) begin
          fail("extra_beat", n_beats, -1);
        end else begin
          e_mon = q.pop_front();
          check($sformatf("pix m%0d r%0d c%0d",
                          e_mon.m, e_mon.r, e_mon.c),
                vif_a.pixel_out, e_mon.pix);
          check($sformatf("mark r%0d c%0d", e_mon.r, e_mon.c),
                {vif_a.sof_out, vif_a.eol_out, vif_a.eof_out},
                {e_mon.sof, e_mon.eol, e_mon.eof});
          cap[e_mon.m][e_mon.r][e_mon.c] = vif_a.pixel_out;
        end
        n_beats++;
      end
      stall_prev = vif_a.valid_out && !vif_a.ready_in;
      held = {vif_a.valid_out, vif_a.sof_out, vif_a.eol_out,
              vif_a.eof_out, vif_a.pixel_out};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{3'd0, 0, 0, 8'h00};
    vt[1]  = '{3'd0, 0, 2, 8'hFF};
    vt[2]  = '{3'd0, 0, 5, 8'h00};
    vt[3]  = '{3'd0, 2, 0, 8'hFF};
    vt[4]  = '{3'd0, 2, 3, 8'h00};
    vt[5]  = '{3'd0, 7, 4, 8'hFF};
    vt[6]  = '{3'd1, 0, 7, 8'h07};
    vt[7]  = '{3'd1, 5, 3, 8'h03};
    vt[8]  = '{3'd2, 6, 1, 8'h06};
    vt[9]  = '{3'd2, 0, 7, 8'h00};
    vt[10] = '{3'd3, 4, 4, 8'hFF};
    vt[11] = '{3'd4, 7, 7, 8'h0E};
    vt[12] = '{3'd4, 3, 2, 8'h05};
    vt[13] = '{3'd6, 5, 5, 8'h00};

    rst_n = 1'b0;
    enable = 1'b0;
    en_b = 1'b0;
    mode = 3'd0;
    mode_b = 3'd1;
    vif_b.ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", vif_a.valid_out, 0);
    check("rst_pixel", vif_a.pixel_out, 0);
    check("rst_marks", {vif_a.sof_out, vif_a.eol_out,
                        vif_a.eof_out}, 0);
    check("rst_fcnt", fcnt_a, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    push_frame(3'd0, fc);
    enable = 1'b1;
    @(negedge clk);
    check("lat_pre", vif_a.valid_out, 0);
    @(posedge clk);
    #1;
    enable = 1'b0;
    check("lat_post", vif_a.valid_out, 1);
    check("lat_sof", vif_a.sof_out, 1);
    wait_drain(200);
    fc++;
    check("fcnt_f0", fcnt_a, fc);
    check("idle_f0", vif_a.valid_out, 0);

    base = n_beats;
    push_frame(3'd3, fc);
    mode = 3'd3;
    enable = 1'b1;
    wait_beats(base + 20, 200);
    enable = 1'b0;
    mode = 3'd7;
    wait_drain(200);
    fc++;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_eof", vif_a.valid_out, 0);
    check("fcnt_f1", fcnt_a, fc);

    push_frame(3'd4, fc);
    mode = 3'd4;
    bp_en = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_drain(1000);
    bp_en = 1'b0;
    fc++;
    check("fcnt_f2", fcnt_a, fc);

    base = n_beats;
    push_frame(3'd1, fc);
    push_frame(3'd2, fc + 1);
    mode = 3'd1;
    enable = 1'b1;
    wait_beats(base + 10, 200);
    mode = 3'd2;
    wait_beats(base + 70, 200);
    enable = 1'b0;
    wait_drain(400);
    fc += 2;
    check("fcnt_f4", fcnt_a, fc);

    push_frame(3'd6, fc);
    mode = 3'd6;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_drain(200);
    fc++;
    check("fcnt_f5", fcnt_a, fc);

    for (int i = 0; i < 14; i++)
      check($sformatf("vec%0d m%0d r%0d c%0d", i, vt[i].m,
                      vt[i].r, vt[i].c),
            cap[vt[i].m][vt[i].r][vt[i].c], vt[i].exp);

    base = n_beats;
    push_frame(3'd0, fc);
    mode = 3'd0;
    enable = 1'b1;
    wait_beats(base + 37, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", vif_a.valid_out, 0);
    check("mrst_pixel", vif_a.pixel_out, 0);
    check("mrst_marks", {vif_a.sof_out, vif_a.eol_out,
                         vif_a.eof_out}, 0);
    check("mrst_fcnt", fcnt_a, 0);
    q.delete();
    fc = 0;
    mode = 3'd5;
    bp_en = 1'b1;
    for (int f = 0; f < 5; f++) push_frame(3'd5, f);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_fcnt", fcnt_a, 0);
    base = n_beats;
    wait_beats(base + 4 * 64 + 5, 3000);
    enable = 1'b0;
    wait_drain(1000);
    bp_en = 1'b0;
    check("fcnt_bar", fcnt_a, 5);
    check("bar_wrap_c0", cap[5][0][0], 8'hFF);
    check("bar_wrap_c2", cap[5][3][2], 8'h00);
    check("bar_wrap_c7", cap[5][7][7], 8'h00);

    en_b = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!vif_b.valid_out && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!vif_b.valid_out) fail("hb_start_timeout", n, 10);
    end
    for (int i = 0; i < 176; i++) begin
      int ph;
      logic vexp;
      ph = i % 11;
      vexp = (ph < 8);
      check($sformatf("hblank i%0d", i),
            {vif_b.valid_out,
             vif_b.eol_out & vif_b.valid_out,
             vif_b.valid_out ? vif_b.pixel_out : 8'h00},
            {vexp, vexp && (ph == 7),
             vexp ? 8'(ph) : 8'h00});
      @(negedge clk);
    end
    en_b = 1'b0;
    check("hb_fcnt", fcnt_b, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
